// File: rtl/nios_mult_pipe.sv
// Pipelined DATA_W x DATA_W multiplier with Nios MUL/MULX ops.
// Valid/ready flow control, tag pass-through and synchronous flush.
module nios_mult_pipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [1:0]        op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int HALF_W = DATA_W / 2;
    localparam int PW     = 2 * DATA_W;

    logic adv;
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // Half-width partial products of the current operands
    logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
    logic [DATA_W-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

    assign a_lo  = src1[HALF_W-1:0];
    assign a_hi  = src1[DATA_W-1:HALF_W];
    assign b_lo  = src2[HALF_W-1:0];
    assign b_hi  = src2[DATA_W-1:HALF_W];
    assign pp_ll = {{HALF_W{1'b0}}, a_lo} * {{HALF_W{1'b0}}, b_lo};
    assign pp_lh = {{HALF_W{1'b0}}, a_lo} * {{HALF_W{1'b0}}, b_hi};
    assign pp_hl = {{HALF_W{1'b0}}, a_hi} * {{HALF_W{1'b0}}, b_lo};
    assign pp_hh = {{HALF_W{1'b0}}, a_hi} * {{HALF_W{1'b0}}, b_hi};

    logic              s1_valid;
    logic [1:0]        s1_op;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_ll, s1_lh, s1_hl, s1_hh;
    logic [DATA_W-1:0] s1_a, s1_b;
    logic              s1_na, s1_nb;

    // Stage 1 valid: cleared by reset or flush, shifts on advance
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
        end
    end

    // Stage 1 payload: partial products plus sign-correction flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_op  <= '0;
            s1_tag <= '0;
            s1_ll  <= '0;
            s1_lh  <= '0;
            s1_hl  <= '0;
            s1_hh  <= '0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_na  <= 1'b0;
            s1_nb  <= 1'b0;
        end else if (adv && !flush && in_valid) begin
            s1_op  <= op;
            s1_tag <= in_tag;
            s1_ll  <= pp_ll;
            s1_lh  <= pp_lh;
            s1_hl  <= pp_hl;
            s1_hh  <= pp_hh;
            s1_a   <= src1;
            s1_b   <= src2;
            s1_na  <= src1[DATA_W-1] & op[1];
            s1_nb  <= src2[DATA_W-1] & op[1] & op[0];
        end
    end

    // Full-width product recombination with signed corrections
    logic [PW-1:0]     p_hh, p_mid, p_ll, p_ca, p_cb, p_full;
    logic [DATA_W-1:0] p_word;

    assign p_hh   = {s1_hh, {DATA_W{1'b0}}};
    assign p_mid  = ({{DATA_W{1'b0}}, s1_lh} + {{DATA_W{1'b0}}, s1_hl}) << HALF_W;
    assign p_ll   = {{DATA_W{1'b0}}, s1_ll};
    assign p_ca   = s1_na ? {s1_b, {DATA_W{1'b0}}} : '0;
    assign p_cb   = s1_nb ? {s1_a, {DATA_W{1'b0}}} : '0;
    assign p_full = p_hh + p_mid + p_ll - p_ca - p_cb;
    assign p_word = (s1_op == 2'b00) ? p_full[DATA_W-1:0]
                                     : p_full[PW-1:DATA_W];

    logic              st_valid  [2:LATENCY];
    logic [DATA_W-1:0] st_data   [2:LATENCY];
    logic [TAG_W-1:0]  st_tag    [2:LATENCY];
    logic              feed_valid[2:LATENCY];
    logic [DATA_W-1:0] feed_data [2:LATENCY];
    logic [TAG_W-1:0]  feed_tag  [2:LATENCY];
    logic [LATENCY:1]  vbits;

    assign feed_valid[2] = s1_valid;
    assign feed_data[2]  = p_word;
    assign feed_tag[2]   = s1_tag;
    assign vbits[1]      = s1_valid;

    for (genvar g = 3; g <= LATENCY; g++) begin : g_link
        assign feed_valid[g] = st_valid[g-1];
        assign feed_data[g]  = st_data[g-1];
        assign feed_tag[g]   = st_tag[g-1];
    end

    for (genvar g = 2; g <= LATENCY; g++) begin : g_stage
        assign vbits[g] = st_valid[g];

        // Stage valid bit: cleared by reset or flush, shifts on advance
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                st_valid[g] <= 1'b0;
            end else if (flush) begin
                st_valid[g] <= 1'b0;
            end else if (adv) begin
                st_valid[g] <= feed_valid[g];
            end
        end

        // Stage payload only follows valid slots so result holds across bubbles
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                st_data[g] <= '0;
                st_tag[g]  <= '0;
            end else if (adv && !flush && feed_valid[g]) begin
                st_data[g] <= feed_data[g];
                st_tag[g]  <= feed_tag[g];
            end
        end
    end

    assign out_valid = st_valid[LATENCY];
    assign result    = st_data[LATENCY];
    assign out_tag   = st_tag[LATENCY];
    assign busy      = |vbits;

endmodule

// File: doc/nios_mult_pipe.md
Name: nios_mult_pipe

Overview:
- Parametrised, pipelined integer multiplier for the Nios II-class execute/memory path.
- Successor to the fixed three-partial-product 16x16 multiplier cell. Adds:
  - generic operand width;
  - configurable latency;
  - all four Nios multiply ops (low word, high word in uu/su/ss forms);
  - valid/ready flow control with tag pass-through and flush.
- Sits between the E-stage operand muxes and the M/W-stage result mux.

Parameters:
- DATA_W, 32, operand and result width; even, 8..64.
- LATENCY, 2, cycles from input accept to out_valid with no stall; legal range 2..4.
- TAG_W, 5, width of the opaque tag carried alongside each operation (destination register index).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept this cycle.
- src1  in  DATA_W  operand A.
- src2  in  DATA_W  operand B.
- op  in  2  operation select:
  - 00 MUL: low DATA_W bits of product;
  - 01 MULXUU: high DATA_W bits, A and B unsigned;
  - 10 MULXSU: high DATA_W bits, A signed, B unsigned;
  - 11 MULXSS: high DATA_W bits, A and B signed.
- in_tag  in  TAG_W  tag accompanying the operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  DATA_W  selected product word.
- out_tag  out  TAG_W  tag of the presented result.
- busy  out  1  any stage holds a valid operation.

Behaviour:
- Reset (reset_n low at a clock edge):
  - all stage valid bits clear;
  - out_valid=0, result=0, out_tag=0, busy=0;
  - in_ready=1 from the first cycle after reset is released.
  - Reset overrides flush and any handshake in the same cycle.
- Pipeline structure: LATENCY register stages, each holding valid, op, tag and data.
- Stage 1 registers the four HALF_W x HALF_W unsigned partial products:
  - LL, LH, HL, HH, with HALF_W=DATA_W/2;
  - plus two sign-correction flags: A negative and op signed-A; B negative and op signed-B.
- Stage 2 forms the 2*DATA_W unsigned product P = HH<<DATA_W + (LH+HL)<<HALF_W + LL.
  - Signed-A correction subtracts B<<DATA_W when its flag is set.
  - Signed-B correction subtracts A<<DATA_W when its flag is set.
  - All arithmetic is modulo 2^(2*DATA_W).
  - Word select: op=00 -> low word; otherwise -> high word.
- Stages 3..LATENCY are pure delay registers (retiming slack).
- Result, out_tag and out_valid are driven from the last stage register; no combinational path from src/op to result.
- Flow control:
  - Global advance enable adv = !out_valid | out_ready.
  - in_ready = adv; there are no bubbles to collapse.
  - When adv=1, every stage shifts forward by one. Stage 1 loads in_valid & in_ready; invalid slots propagate as bubbles.
  - When adv=0, all stages, including data, hold their values. result and out_tag stay stable while out_valid=1 && out_ready=0.
- Throughput: one operation per cycle with out_ready held high. Latency is exactly LATENCY cycles from accept edge to out_valid.
- Simultaneous in_valid/in_ready and out_valid/out_ready in the same cycle: both transfers occur and the pipeline shifts.
- Flush:
  - On an edge with flush=1, all stage valid bits clear; data registers may keep stale values.
  - An operation offered in the same cycle is not accepted.
  - out_valid=0 on the next cycle.
- busy = OR of all stage valid bits.
- Invalid slots do not update result. result holds its last valid value until the next valid result reaches the output stage.

Test Plan:
- DATA_W=32, LATENCY=2, out_ready=1. src1=src2=0xFFFFFFFF with op=00,01,10,11 on consecutive cycles -> results 0x00000001, 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, arriving on consecutive cycles starting 2 cycles after the first accept, tags preserved.
- src1=src2=0x80000000, op=11 -> result 0x40000000. op=01 -> 0x40000000. op=00 -> 0x00000000. src1=0x00012345, src2=0x00010000, op=00 -> 0x23450000.
- Backpressure: stream 4 ops, drop out_ready for 3 cycles while out_valid=1 -> in_ready=0 and result/out_tag stable throughout. Then raise out_ready -> all 4 results delivered in order, none lost or duplicated.
- Flush: accept 2 ops, assert flush 1 cycle later -> no out_valid for either. busy=0 the next cycle. A new op after flush completes normally with correct value.
- Reset mid-operation: pipeline full, reset_n low for 1 cycle -> out_valid=0, result=0, busy=0 next cycle. No stale result appears afterward.
- Parameter sweep: DATA_W=16 and 64, LATENCY=2,3,4. Random operands against a reference model -> bit-exact results at exactly LATENCY cycles with continuous out_ready.
